// File: rtl/jet_pkg.sv
// Shared constants, tower record and FSM encoding for the jet seed scheduler.
package jet_pkg;
    localparam int CW       = 10;
    localparam int PHI_WRAP = 62;
    localparam int PHI_HALF = 31;
    localparam int R2_CUT   = 100;
    localparam int R2W      = 2 * CW + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_SCAN = 2'd2;
    localparam logic [1:0] ST_EMIT = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        LOAD = ST_LOAD,
        SCAN = ST_SCAN,
        EMIT = ST_EMIT
    } state_t;

    typedef struct packed {
        logic [CW-1:0] eta;
        logic [CW-1:0] phi;
        logic [CW-1:0] et;
        logic [CW-1:0] e;
    } tower_t;

    function automatic logic [CW-1:0] abs_diff(input logic [CW-1:0] a, input logic [CW-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction
endpackage

// File: rtl/jet_delta_r2.sv
// Combinational delta-R^2 between two towers; phi distance folds around the 62-bin ring.
module jet_delta_r2
    import jet_pkg::*;
(
    input  tower_t         a,
    input  tower_t         b,
    output logic [R2W-1:0] dr2
);
    logic [CW-1:0] deta;
    logic [CW-1:0] dphi_raw;
    logic [CW-1:0] dphi;

    always_comb begin
        deta     = abs_diff(a.eta, b.eta);
        dphi_raw = abs_diff(a.phi, b.phi);
        dphi     = (dphi_raw > CW'(PHI_HALF)) ? (CW'(PHI_WRAP) - dphi_raw) : dphi_raw;
        dr2      = (R2W'(deta) * R2W'(deta)) + (R2W'(dphi) * R2W'(dphi));
    end
endmodule

// File: rtl/jet_seed_scheduler.sv
// Buffers one event of Et-sorted towers, suppresses seeds near higher-Et kept seeds, streams survivors.
// Optional feature macro JET_SEL_ET_THRESH_EN adds a seed_et_min input that filters towers at load time.
module jet_seed_scheduler #(
    parameter int MAX_TOWERS = 64,
    parameter int CW         = jet_pkg::CW,
    parameter int R2_CUT     = jet_pkg::R2_CUT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_last,
    input  logic [CW-1:0]                 in_eta,
    input  logic [CW-1:0]                 in_phi,
    input  logic [CW-1:0]                 in_et,
    input  logic [CW-1:0]                 in_e,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last,
    output logic [CW-1:0]                 out_eta,
    output logic [CW-1:0]                 out_phi,
    output logic [CW-1:0]                 out_et,
    output logic [CW-1:0]                 out_e,
    output logic                          busy,
    output logic                          ovf,
    output logic [$clog2(MAX_TOWERS):0]   seed_count
`ifdef JET_SEL_ET_THRESH_EN
    ,
    input  logic [CW-1:0]                 seed_et_min
`endif
);
    import jet_pkg::*;

    localparam int IW   = $clog2(MAX_TOWERS);
    localparam int IDXW = IW + 1;
    localparam logic [IDXW-1:0] ONE   = IDXW'(1);
    localparam logic [IDXW-1:0] MAX_N = IDXW'(MAX_TOWERS);

    logic [1:0]            state_reg;
    logic [IDXW-1:0]       n_reg;
    logic [IDXW-1:0]       i_reg;
    logic [IDXW-1:0]       j_reg;
    logic [IDXW-1:0]       ptr_reg;
    logic [IDXW-1:0]       seed_count_reg;
    logic [MAX_TOWERS-1:0] kept_reg;
    logic                  hit_reg;
    logic                  ovf_reg;
    logic                  out_valid_reg;
    logic                  out_last_reg;
    tower_t                out_reg;
    tower_t                buffer [MAX_TOWERS];
`ifdef JET_SEL_ET_THRESH_EN
    logic [CW-1:0]         et_min_reg;
`endif

    tower_t          in_tower;
    logic            in_hs;
    logic            tower_pass;
    logic            room;
    logic            wr_en;
    logic            drop;
    logic [IDXW-1:0] n_next;

    assign in_tower = {in_eta, in_phi, in_et, in_e};
    assign in_hs    = in_valid && (state_reg == ST_LOAD);
`ifdef JET_SEL_ET_THRESH_EN
    assign tower_pass = (in_et >= et_min_reg);
`else
    assign tower_pass = 1'b1;
`endif
    assign room   = (n_reg < MAX_N);
    assign wr_en  = in_hs && tower_pass && room;
    assign drop   = in_hs && tower_pass && !room;
    assign n_next = n_reg + {{IW{1'b0}}, wr_en};

    // Tower storage carries no reset; its contents are only meaningful below n_reg.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buffer[n_reg[IW-1:0]] <= in_tower;
        end
    end

    tower_t          tower_i;
    tower_t          tower_j;
    logic [R2W-1:0]  dr2;
    logic            issue;

    assign tower_i = buffer[i_reg[IW-1:0]];
    assign tower_j = buffer[j_reg[IW-1:0]];

    jet_delta_r2 u_delta_r2 (
        .a   (tower_i),
        .b   (tower_j),
        .dr2 (dr2)
    );

    // No pair is issued in the cycle a hit returns: that slot is the discarded in-flight pair.
    assign issue = (state_reg == ST_SCAN) && !hit_reg && (i_reg < n_reg) &&
                   (j_reg < i_reg) && kept_reg[j_reg[IW-1:0]];

    logic [MAX_TOWERS-1:0] ptr_mask;
    logic [MAX_TOWERS-1:0] avail;
    logic [MAX_TOWERS-1:0] avail_rest;
    logic                  next_found;
    logic [IW-1:0]         next_idx;
    logic                  next_is_last;

    generate
        for (genvar gi = 0; gi < MAX_TOWERS; gi++) begin : g_ptr_mask
            assign ptr_mask[gi] = (IDXW'(gi) >= ptr_reg);
        end
    endgenerate

    assign avail = kept_reg & ptr_mask;

    always_comb begin
        next_found = 1'b0;
        next_idx   = '0;
        for (int k = MAX_TOWERS - 1; k >= 0; k--) begin
            if (avail[k]) begin
                next_found = 1'b1;
                next_idx   = IW'(k);
            end
        end
    end

    assign avail_rest   = avail & ~(MAX_TOWERS'(1) << next_idx);
    assign next_is_last = (avail_rest == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            n_reg          <= '0;
            i_reg          <= '0;
            j_reg          <= '0;
            ptr_reg        <= '0;
            seed_count_reg <= '0;
            kept_reg       <= '0;
            hit_reg        <= 1'b0;
            ovf_reg        <= 1'b0;
            out_valid_reg  <= 1'b0;
            out_last_reg   <= 1'b0;
            out_reg        <= '0;
`ifdef JET_SEL_ET_THRESH_EN
            et_min_reg     <= '0;
`endif
        end else begin
            hit_reg <= issue && (dr2 < R2W'(R2_CUT));
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        state_reg      <= ST_LOAD;
                        n_reg          <= '0;
                        ovf_reg        <= 1'b0;
                        kept_reg       <= '0;
                        seed_count_reg <= '0;
`ifdef JET_SEL_ET_THRESH_EN
                        et_min_reg     <= seed_et_min;
`endif
                    end
                end
                ST_LOAD: begin
                    n_reg <= n_next;
                    if (drop) begin
                        ovf_reg <= 1'b1;
                    end
                    if (in_hs && in_last) begin
                        state_reg      <= ST_SCAN;
                        i_reg          <= ONE;
                        j_reg          <= '0;
                        kept_reg[0]    <= (n_next != '0);
                        seed_count_reg <= (n_next != '0) ? ONE : '0;
                    end
                end
                ST_SCAN: begin
                    if (i_reg >= n_reg) begin
                        // An event whose towers were all filtered out has nothing to emit.
                        state_reg <= (n_reg == '0) ? ST_IDLE : ST_EMIT;
                        ptr_reg   <= '0;
                    end else if (hit_reg) begin
                        i_reg <= i_reg + ONE;
                        j_reg <= '0;
                    end else if (j_reg >= i_reg) begin
                        kept_reg[i_reg[IW-1:0]] <= 1'b1;
                        seed_count_reg          <= seed_count_reg + ONE;
                        i_reg                   <= i_reg + ONE;
                        j_reg                   <= '0;
                    end else begin
                        j_reg <= j_reg + ONE;
                    end
                end
                default: begin
                    if (out_valid_reg && out_ready && out_last_reg) begin
                        out_valid_reg <= 1'b0;
                        out_last_reg  <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end else if (!out_valid_reg || out_ready) begin
                        if (next_found) begin
                            out_valid_reg <= 1'b1;
                            out_reg       <= buffer[next_idx];
                            out_last_reg  <= next_is_last;
                            ptr_reg       <= {1'b0, next_idx} + ONE;
                        end else begin
                            out_valid_reg <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    assign in_ready   = (state_reg == ST_LOAD);
    assign busy       = (state_reg != ST_IDLE);
    assign out_valid  = out_valid_reg;
    assign out_last   = out_last_reg;
    assign out_eta    = out_reg.eta;
    assign out_phi    = out_reg.phi;
    assign out_et     = out_reg.et;
    assign out_e      = out_reg.e;
    assign ovf        = ovf_reg;
    assign seed_count = seed_count_reg;
endmodule

// File: tb/tb_jet_seed_scheduler.sv
// Self-checking bench for jet_seed_scheduler: directed events plus randomized events with random back-pressure.
module tb_jet_seed_scheduler;
    localparam int CW   = 10;
    localparam int MAXT = 64;
    localparam int IW   = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, in_last;
    logic [CW-1:0] in_eta, in_phi, in_et, in_e;
    logic          out_valid, out_ready, out_last;
    logic [CW-1:0] out_eta, out_phi, out_et, out_e;
    logic          busy, ovf;
    logic [IW:0]   seed_count;
`ifdef JET_SEL_ET_THRESH_EN
    logic [CW-1:0] seed_et_min = '0;
`endif

    jet_seed_scheduler #(.MAX_TOWERS(MAXT), .CW(CW), .R2_CUT(100)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_last    (in_last),
        .in_eta     (in_eta),
        .in_phi     (in_phi),
        .in_et      (in_et),
        .in_e       (in_e),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .out_eta    (out_eta),
        .out_phi    (out_phi),
        .out_et     (out_et),
        .out_e      (out_e),
        .busy       (busy),
        .ovf        (ovf),
        .seed_count (seed_count)
`ifdef JET_SEL_ET_THRESH_EN
        ,
        .seed_et_min(seed_et_min)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int tw_eta[$], tw_phi[$], tw_et[$], tw_e[$];
    int exp_idx[$];
    int exp_ovf;
    logic [4*CW-1:0] got[$];
    int sc_seen_val;

    task automatic clear_towers();
        tw_eta.delete(); tw_phi.delete(); tw_et.delete(); tw_e.delete();
    endtask

    task automatic add_tower(input int eta, input int phi, input int et, input int e);
        tw_eta.push_back(eta); tw_phi.push_back(phi); tw_et.push_back(et); tw_e.push_back(e);
    endtask

    function automatic int model_dr2(input int i, input int j);
        int de, dp;
        de = (tw_eta[i] > tw_eta[j]) ? tw_eta[i] - tw_eta[j] : tw_eta[j] - tw_eta[i];
        dp = (tw_phi[i] > tw_phi[j]) ? tw_phi[i] - tw_phi[j] : tw_phi[j] - tw_phi[i];
        if (dp > 31) dp = 62 - dp;
        return de * de + dp * dp;
    endfunction

    function automatic logic [4*CW-1:0] pack_tower(input int i);
        return {CW'(tw_eta[i]), CW'(tw_phi[i]), CW'(tw_et[i]), CW'(tw_e[i])};
    endfunction

    // Greedy reference: a tower survives if it is far enough from every earlier survivor.
    task automatic build_expected();
        int n;
        bit keep;
        n = (tw_eta.size() > MAXT) ? MAXT : tw_eta.size();
        exp_ovf = (tw_eta.size() > MAXT) ? 1 : 0;
        exp_idx.delete();
        for (int i = 0; i < n; i++) begin
            keep = 1'b1;
            foreach (exp_idx[k]) begin
                if (model_dr2(i, exp_idx[k]) < 100) keep = 1'b0;
            end
            if (keep) exp_idx.push_back(i);
        end
    endtask

    task automatic send_event(input int gap_pct);
        int idx;
        int cyc;
        idx = 0;
        cyc = 0;
        while (idx < tw_eta.size() && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if ($urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_eta   = CW'(tw_eta[idx]);
                in_phi   = CW'(tw_phi[idx]);
                in_et    = CW'(tw_et[idx]);
                in_e     = CW'(tw_e[idx]);
                in_last  = (idx == tw_eta.size() - 1);
                if (in_ready) idx++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (idx != tw_eta.size()) begin
            errors++;
            $display("FAIL send_timeout: accepted %0d towers, required %0d", idx, tw_eta.size());
        end
    endtask

    task automatic recv_event(input int ready_pct);
        int cyc;
        bit done, stall, sc_seen;
        logic [4*CW-1:0] stall_val;
        cyc = 0; done = 0; stall = 0; sc_seen = 0;
        sc_seen_val = -1;
        while (!done && cyc < 30000) begin
            @(negedge clk);
            cyc++;
            if (stall) begin
                checks++;
                if (out_valid !== 1'b1 || {out_eta, out_phi, out_et, out_e} !== stall_val) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%b data=%h, required valid=1 data=%h",
                             out_valid, {out_eta, out_phi, out_et, out_e}, stall_val);
                end
            end
            if (out_valid && !sc_seen) begin
                sc_seen = 1;
                sc_seen_val = int'(seed_count);
            end
            out_ready = ($urandom_range(99) < ready_pct);
            stall = out_valid && !out_ready;
            stall_val = {out_eta, out_phi, out_et, out_e};
            if (out_valid && out_ready) begin
                got.push_back({out_eta, out_phi, out_et, out_e});
                checks++;
                if (out_last !== (got.size() == exp_idx.size())) begin
                    errors++;
                    $display("FAIL out_last: seed %0d got %b, required %b",
                             got.size() - 1, out_last, (got.size() == exp_idx.size()));
                end
                if (out_last || got.size() > exp_idx.size()) done = 1;
            end
        end
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL recv_timeout: got %0d seeds, required %0d", got.size(), exp_idx.size());
        end else if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_emit: busy got %b, required 0", busy);
        end
    endtask

    task automatic run_event(input string name, input int ready_pct, input int gap_pct);
        build_expected();
        got.delete();
        fork
            send_event(gap_pct);
            recv_event(ready_pct);
        join
        checks++;
        if (got.size() != exp_idx.size()) begin
            errors++;
            $display("FAIL %s_count: got %0d seeds, required %0d", name, got.size(), exp_idx.size());
        end
        for (int k = 0; k < got.size() && k < exp_idx.size(); k++) begin
            checks++;
            if (got[k] !== pack_tower(exp_idx[k])) begin
                errors++;
                $display("FAIL %s_seed%0d: got %h, required %h", name, k, got[k], pack_tower(exp_idx[k]));
            end
        end
        checks++;
        if (sc_seen_val != exp_idx.size()) begin
            errors++;
            $display("FAIL %s_seed_count: got %0d, required %0d", name, sc_seen_val, exp_idx.size());
        end
        checks++;
        if (ovf !== exp_ovf[0]) begin
            errors++;
            $display("FAIL %s_ovf: got %b, required %0d", name, ovf, exp_ovf);
        end
        $display("event %s: towers=%0d seeds=%0d expected=%0d ovf=%b", name, tw_eta.size(),
                 got.size(), exp_idx.size(), ovf);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        in_eta = '0; in_phi = '0; in_et = '0; in_e = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, out_valid, out_last, busy, ovf} !== 5'b0 || seed_count !== '0 ||
            {out_eta, out_phi, out_et, out_e} !== '0) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b v=%b l=%b busy=%b ovf=%b sc=%0d data=%h, required all 0",
                     in_ready, out_valid, out_last, busy, ovf, seed_count, {out_eta, out_phi, out_et, out_e});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        clear_towers(); add_tower(5, 5, 500, 600);
        run_event("single", 100, 0);
        clear_towers(); add_tower(10, 10, 400, 410); add_tower(15, 15, 300, 310);
        run_event("close_pair", 100, 0);
        clear_towers(); add_tower(10, 10, 400, 410); add_tower(20, 10, 300, 310);
        run_event("boundary_pair", 60, 20);
        clear_towers(); add_tower(0, 1, 400, 1); add_tower(0, 60, 300, 2);
        run_event("phi_wrap", 100, 0);
        clear_towers(); add_tower(0, 0, 900, 3); add_tower(0, 8, 800, 4); add_tower(0, 16, 700, 5);
        run_event("chain", 50, 30);
    endtask

    task automatic test_overflow();
        clear_towers();
        for (int i = 0; i < 65; i++) add_tower((i % 32) * 20, (i / 32) * 20, 1000 - i * 10, i);
        run_event("overflow", 50, 10);
    endtask

    task automatic test_reset_mid_scan();
        clear_towers();
        for (int i = 0; i < 64; i++) add_tower((i % 32) * 20, (i / 32) * 20, 1000 - i * 10, 100 + i);
        send_event(0);
        repeat (50) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_scan_state: got busy=%b out_valid=%b, required busy=1 out_valid=0", busy, out_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || seed_count !== '0) begin
            errors++;
            $display("FAIL mid_scan_reset: got busy=%b out_valid=%b sc=%0d, required 0 0 0",
                     busy, out_valid, seed_count);
        end
        rst = 1'b0;
        @(negedge clk);
        clear_towers(); add_tower(0, 0, 900, 7); add_tower(0, 8, 800, 8); add_tower(0, 16, 700, 9);
        run_event("after_reset", 70, 10);
    endtask

    task automatic test_random();
        int n;
        for (int ev = 0; ev < 8; ev++) begin
            clear_towers();
            n = $urandom_range(24, 1);
            for (int i = 0; i < n; i++)
                add_tower($urandom_range(60), $urandom_range(61), 1000 - i * 20, $urandom_range(1023));
            run_event($sformatf("random%0d", ev), 70, 25);
        end
    endtask

    task automatic test_back_to_back();
        clear_towers(); add_tower(3, 40, 700, 11); add_tower(30, 2, 600, 12);
        run_event("b2b_a", 100, 0);
        clear_towers(); add_tower(8, 8, 700, 13); add_tower(9, 9, 600, 14); add_tower(40, 40, 500, 15);
        run_event("b2b_b", 100, 0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_overflow();
        test_back_to_back();
        test_reset_mid_scan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
